// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// SPI transmitter. The winner's byte is captured once and held on spi_data_in.
// spi_load is held high for LOAD_CYCLES cycles. The transfer then completes on
// a rising edge of spi_done.
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles. A timed-out transfer still acks its owner, with err set.
//
// state | meaning
// IDLE  | no transfer; arbitrate among pending requests
// LOAD  | spi_load high, byte presented to the transmitter
// WAIT  | waiting for a fresh rising edge of spi_done (or timeout)
// ACK   | one-cycle ack pulse to the owner, grant still held
module spi_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic                      busy,
    output logic [DATA_W-1:0]         spi_data_in,
    output logic                      spi_load,
    input  logic                      spi_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner;
    logic [LW-1:0] load_cnt;
    logic          spi_done_q;
    logic          done_rise;
    logic          timeout_hit;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;

    assign done_rise = spi_done & ~spi_done_q;

    // Round-robin pick. Scanning from the far end lets the nearest requester
    // after last_grant overwrite the others, so no found flag is needed.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(last_grant) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // spi_done history for edge detection, sampled every cycle regardless of state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) spi_done_q <= 1'b0;
        else       spi_done_q <= spi_done;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (to_cnt == TW'(TIMEOUT - 1));
    assign err         = err_q;

    // WAIT-cycle counter: zero outside WAIT, so it starts at zero on every WAIT entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 to_cnt <= '0;
        else if (state == S_WAIT)  to_cnt <= to_cnt + 1'b1;
        else                       to_cnt <= '0;
    end

    // err marks an ACK entered by timeout. A simultaneous spi_done edge wins, so err stays low then.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= (state == S_WAIT) && !done_rise && timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Transfer sequencer; all outputs are registered here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            spi_load    <= 1'b0;
            spi_data_in <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            owner       <= '0;
            load_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state       <= S_LOAD;
                        owner       <= pick_idx;
                        grant       <= ONE_HOT0 << pick_idx;
                        spi_data_in <= req_data[pick_idx*DATA_W +: DATA_W];
                        spi_load    <= 1'b1;
                        busy        <= 1'b1;
                        load_cnt    <= LW'(LOAD_CYCLES - 1);
                    end
                end
                S_LOAD: begin
                    if (load_cnt == '0) begin
                        state    <= S_WAIT;
                        spi_load <= 1'b0;
                    end else begin
                        load_cnt <= load_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (done_rise || timeout_hit) begin
                        state      <= S_ACK;
                        ack        <= grant;
                        last_grant <= owner;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    grant    <= '0;
                    ack      <= '0;
                    busy     <= 1'b0;
                    spi_load <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Testbench for spi_tx_arbiter: directed scenarios with literal expectations,
// then a randomized phase. A transfer-timeline model is compared every cycle.
module tb_spi_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int LC = 2;
    localparam int TO = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  grant;
    logic [NR-1:0]  ack;
    logic           err;
    logic           busy;
    logic [DW-1:0]  spi_data_in;
    logic           spi_load;
    logic           spi_done = 1'b0;

    int vec = 0;
    int bad = 0;

    spi_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LOAD_CYCLES(LC), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .ack(ack), .err(err), .busy(busy),
        .spi_data_in(spi_data_in), .spi_load(spi_load), .spi_done(spi_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transfer is described by its start cycle s, its owner and its ack cycle.
    // spi_load is high for cycles s..s+LC-1. Completion needs a spi_done rise at some cycle > s+LC,
    // or, with the timeout, the transfer reaches s+LC+TO. The cycle after ack is idle.
    int   m_n = 0;
    bit   m_active = 0;
    int   m_s = 0;
    int   m_ack_at = -1;
    bit   m_err = 0;
    int   m_owner = 0;
    int   m_last = NR - 1;
    logic [DW-1:0] m_cap = '0;
    bit   m_prev_done = 0;
    bit   m_found;
    int   m_c;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_n = 0; m_active = 0; m_ack_at = -1; m_err = 0;
            m_owner = 0; m_last = NR - 1; m_cap = '0; m_prev_done = 0;
        end else begin
            m_n++;
            if (m_active && m_ack_at == m_n - 1) begin
                m_active = 0;
                m_last   = m_owner;
                m_ack_at = -1;
            end else if (!m_active && req != '0) begin
                m_found = 0;
                for (int k = 1; k <= NR; k++) begin
                    m_c = (m_last + k) % NR;
                    if (!m_found && req[m_c]) begin
                        m_found = 1;
                        m_owner = m_c;
                    end
                end
                m_active = 1;
                m_s      = m_n;
                m_cap    = req_data[m_owner*DW +: DW];
                m_err    = 0;
            end else if (m_active && m_ack_at < 0 && m_n > m_s + LC) begin
                if (spi_done && !m_prev_done) begin
                    m_ack_at = m_n;
                    m_err    = 0;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (m_n == m_s + LC + TO) begin
                    m_ack_at = m_n;
                    m_err    = 1;
                end
`endif
            end
            m_prev_done = spi_done;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NR-1:0] e_grant, e_ack;
    logic          e_load, e_err;

    always @(negedge clock) begin
        if (!reset) begin
            e_grant = m_active ? (NR'(1) << m_owner) : '0;
            e_ack   = (m_active && m_ack_at == m_n) ? (NR'(1) << m_owner) : '0;
            e_load  = m_active && (m_n < m_s + LC);
            e_err   = (e_ack != '0) && m_err;
            chk("model busy",     32'(busy),     32'(m_active));
            chk("model grant",    32'(grant),    32'(e_grant));
            chk("model ack",      32'(ack),      32'(e_ack));
            chk("model err",      32'(err),      32'(e_err));
            chk("model spi_load", 32'(spi_load), 32'(e_load));
            if (m_active) chk("model spi_data_in", 32'(spi_data_in), 32'(m_cap));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
    endtask

    task automatic wait_busy(input string nm);
        int t = 0;
        while (!busy && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk({nm, " start"}, 32'(busy), 32'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic xfer(input logic [3:0] eg, input logic [7:0] ed, input string nm);
        wait_busy(nm);
        chk({nm, " grant"}, 32'(grant), 32'(eg));
        chk({nm, " data"},  32'(spi_data_in), 32'(ed));
        chk({nm, " load"},  32'(spi_load), 32'(1));
        step();
        step();
        chk({nm, " wait load"}, 32'(spi_load), 32'(0));
        spi_done = 1'b1;
        step();
        chk({nm, " ack"}, 32'(ack), 32'(eg));
        chk({nm, " err"}, 32'(err), 32'(0));
        spi_done = 1'b0;
        step();
        chk({nm, " idle"}, 32'(busy), 32'(0));
    endtask

    logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        // reset held for 20 ns
        step();
        step();
        chk("rst grant", 32'(grant), 32'(0));
        chk("rst ack",   32'(ack),   32'(0));
        chk("rst err",   32'(err),   32'(0));
        chk("rst busy",  32'(busy),  32'(0));
        chk("rst load",  32'(spi_load), 32'(0));
        chk("rst data",  32'(spi_data_in), 32'(0));
        reset = 1'b0;

        // single request
        req = 4'b0001;
        req_data[7:0] = 8'hC6;
        step();
        chk("single grant", 32'(grant), 32'(4'b0001));
        chk("single data",  32'(spi_data_in), 32'(8'hC6));
        chk("single load1", 32'(spi_load), 32'(1));
        step();
        chk("single load2", 32'(spi_load), 32'(1));
        step();
        chk("single load3", 32'(spi_load), 32'(0));
        chk("single noack", 32'(ack), 32'(0));
        spi_done = 1'b1;
        step();
        chk("single ack", 32'(ack), 32'(4'b0001));
        chk("single err", 32'(err), 32'(0));
        req = '0;
        spi_done = 1'b0;
        step();
        chk("single busy", 32'(busy), 32'(0));
        chk("single ack off", 32'(ack), 32'(0));

        // round-robin with all requesters held
        pulse_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            xfer(rr_g[k], rr_d[k], $sformatf("rr%0d", k));
        end
        req = '0;
        step();

        // stale done: level already high when WAIT starts
        req = 4'b0100;
        req_data[23:16] = 8'h5A;
        wait_busy("stale");
        chk("stale grant", 32'(grant), 32'(4'b0100));
        step();
        spi_done = 1'b1;
        step();
        repeat (3) begin
            step();
            chk("stale hold ack", 32'(ack), 32'(0));
            chk("stale hold busy", 32'(busy), 32'(1));
        end
        spi_done = 1'b0;
        step();
        chk("stale low ack", 32'(ack), 32'(0));
        spi_done = 1'b1;
        step();
        chk("stale ack", 32'(ack), 32'(4'b0100));
        req = '0;
        spi_done = 1'b0;
        step();
        chk("stale idle", 32'(busy), 32'(0));

        // early drop during LOAD
        req = 4'b0100;
        req_data[23:16] = 8'h7E;
        wait_busy("drop");
        chk("drop data", 32'(spi_data_in), 32'(8'h7E));
        step();
        req = '0;
        step();
        spi_done = 1'b1;
        step();
        chk("drop ack", 32'(ack), 32'(4'b0100));
        spi_done = 1'b0;
        step();
        chk("drop idle", 32'(busy), 32'(0));

        // asynchronous reset mid-WAIT
        req = 4'b0001;
        wait_busy("rstw");
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("rstw grant", 32'(grant), 32'(0));
        chk("rstw load",  32'(spi_load), 32'(0));
        chk("rstw busy",  32'(busy), 32'(0));
        req = 4'b1010;
        step();
        reset = 1'b0;
        step();
        chk("rstw regrant", 32'(grant), 32'(4'b0010));
        step();
        step();
        spi_done = 1'b1;
        step();
        chk("rstw ack", 32'(ack), 32'(4'b0010));
        req = '0;
        spi_done = 1'b0;
        step();

        // WAIT with spi_done stuck low
        req = 4'b0001;
        wait_busy("tmo");
        step();
        step();
`ifdef SPI_ARB_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            step();
            chk("tmo early ack", 32'(ack), 32'(0));
        end
        step();
        chk("tmo ack", 32'(ack), 32'(4'b0001));
        chk("tmo err", 32'(err), 32'(1));
        req = '0;
        step();
        chk("tmo ack off", 32'(ack), 32'(0));
        chk("tmo err off", 32'(err), 32'(0));
        chk("tmo idle",    32'(busy), 32'(0));
`else
        repeat (40) begin
            step();
            chk("stuck busy", 32'(busy), 32'(1));
            chk("stuck err",  32'(err), 32'(0));
        end
        spi_done = 1'b1;
        step();
        chk("stuck ack", 32'(ack), 32'(4'b0001));
        req = '0;
        spi_done = 1'b0;
        step();
`endif

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (reset) reset = 1'b0;
            else if ($urandom_range(999, 0) == 0) reset = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(7, 0) == 0) begin
                    req_data[i*DW +: DW] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(63, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if ($urandom_range(3, 0) == 0) spi_done = ~spi_done;
        end
        req = '0;
        reset = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- NUM_REQ, 4, number of requesters.
- DATA_W, 8, byte width sent to the SPI transmitter.
- LOAD_CYCLES, 2, cycles spi_load is held high per transfer.
- TIMEOUT, 1024, WAIT-state cycle limit; used only with SPI_ARB_TIMEOUT_EN.

REQ-002 Ports SHALL be as follows, one per line.
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- req, in, NUM_REQ, per-requester transfer request; level, held until ack.
- req_data, in, NUM_REQ*DATA_W, flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- grant, out, NUM_REQ, one-hot owner of the current transfer.
- ack, out, NUM_REQ, one-cycle completion pulse to the owner.
- err, out, 1, timeout flag, coincident with ack.
- busy, out, 1, high in any state other than IDLE.
- spi_data_in, out, DATA_W, byte driven to the transmitter's data_in.
- spi_load, out, 1, drives the transmitter's load_data.
- spi_done, in, 1, the transmitter's done_send.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, WAIT and ACK, with a registered state and registered outputs.
REQ-004 In IDLE with req nonzero, the block SHALL select a winner round-robin.
- Search starts at last_grant+1 and wraps modulo NUM_REQ.
- Next cycle: grant is one-hot, spi_data_in = winner's payload (captured once, held stable), spi_load=1, state=LOAD.
REQ-005 Latency from req sampled high in IDLE to spi_load high SHALL be exactly 1 cycle.
REQ-006 LOAD SHALL last exactly LOAD_CYCLES cycles with spi_load=1, then go to WAIT with spi_load=0.
REQ-007 In WAIT, the block SHALL detect a rising edge of spi_done (spi_done & ~spi_done_q), then go to ACK.
- spi_done_q is registered continuously.
- A spi_done level already high when WAIT is entered SHALL NOT complete the transfer.
REQ-008 ACK SHALL last 1 cycle.
- ack[winner]=1; grant held; last_grant updated to winner.
- Next state IDLE with grant=0.
- Back-to-back transfers SHALL therefore have exactly one IDLE cycle between ACK and the next spi_load.
REQ-009 A requester that drops req after grant SHALL NOT abort the transfer; it completes and ack still pulses.
REQ-010 req changes outside IDLE SHALL be ignored until the next IDLE arbitration.
REQ-011 The block SHALL satisfy these invariants:
- ack is zero outside ACK.
- grant is zero in IDLE.
- At most one grant or ack bit is set.
- busy = (state != IDLE).

Reset
REQ-012 Reset SHALL force the following state, at any time including mid-transfer:
- Outputs: state=IDLE; grant, ack, err, busy, spi_load, spi_data_in = 0.
- Internal: spi_done_q=0, timeout counter=0.
- last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-013 After reset deasserts, the first arbitration SHALL occur on the first clock edge at which req is nonzero.

Configuration
REQ-014 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
- Reaching TIMEOUT without a spi_done edge forces ACK with ack[winner]=1 and err=1 for that single cycle.
- err=0 on normal completion.
REQ-015 With SPI_ARB_TIMEOUT_EN undefined:
- No counter SHALL be synthesized.
- err SHALL be tied to 0.
- WAIT SHALL persist until a spi_done rising edge.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Single request: reset 20 ns; req=4'b0001, req_data[7:0]=8'hC6 -> next cycle grant=0001, spi_data_in=C6, spi_load high 2 cycles; spi_done pulse -> ack=0001 one cycle after the edge; busy low next cycle.
- Round-robin: req=4'b1111 held, payloads 11/22/33/44 -> grant order 0001,0010,0100,1000,0001; spi_data_in matches each owner.
- Stale done: spi_done held high entering WAIT -> no ack until spi_done falls and rises again.
- Early drop: req[2] deasserted during LOAD -> transfer completes, ack=0100 pulses.
- Reset mid-WAIT: reset asserted asynchronously -> grant, spi_load, busy = 0 immediately; next req=4'b1010 grants 0010 first.
- SPI_ARB_TIMEOUT_EN, TIMEOUT=16, spi_done held low -> 16 WAIT cycles, then ack and err high together for 1 cycle; without the macro, err stays 0 and busy stays high.
